// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: definitions shared by the pipeline hazard controller.
//   OP_LOAD             - opcode of a load instruction (RV32 LOAD major opcode)
//   MEM_TIMEOUT_DEFAULT - default limit on consecutive memory-wait cycles
//   state_t             - controller FSM state encodings
//   is_load_use()       - load-use hazard detection between execute and decode
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LOAD             = 7'b0000011;
    localparam int         MEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // A load in execute whose destination (other than x0) feeds decode.
    function automatic logic is_load_use(
        input logic [6:0] opcode,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return (opcode == OP_LOAD) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// pipe_ctrl_perf_cnt: saturating event counter.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   inc   - count one event this cycle
//   count - current count; holds at all-ones once reached
module pipe_ctrl_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: increments on an event, stops at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble controller for a 5-stage in-order pipeline.
// Resolves memory waits, branch mispredicts and load-use hazards, in that
// priority, into per-stage hold (stall) and squash (bubble) controls.
//
// Ports:
//   clk_i, rst_i              - clock; synchronous active-high reset
//   D_rs1_i, D_rs2_i          - sources of the instruction in decode
//   E_opcode_i, E_rd_i        - opcode/destination of the instruction in execute
//   e_mispredict_i            - execute redirects the PC this cycle
//   m_mem_req_i, m_mem_ready_i- memory stage request/ready handshake
//   F/D/E/M_stall_o           - stage hold controls (combinational)
//   D/E/M/W_bubble_o          - stage squash controls (combinational)
//   mem_timeout_o             - sticky: a memory wait reached MEM_TIMEOUT cycles
//   stall_cnt_o, flush_cnt_o  - performance counters
//
// Build option: define PIPE_CTRL_PERF_EN to build the saturating performance
// counters; otherwise the counter ports are tied to zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       D_rs1_i,
    input  logic [4:0]       D_rs2_i,
    input  logic [6:0]       E_opcode_i,
    input  logic [4:0]       E_rd_i,
    input  logic             e_mispredict_i,
    input  logic             m_mem_req_i,
    input  logic             m_mem_ready_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_bubble_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // One spare bit so the incremented count can always be compared with the limit.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_CMP = WAIT_W'(MEM_TIMEOUT);

    state_t            state_r;
    state_t            state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_next_s;
    logic [WAIT_W-1:0] wait_inc_s;
    logic              timeout_r;
    logic              timeout_set_s;
    logic              mem_wait_s;
    logic              load_use_s;

    assign mem_wait_s = m_mem_req_i & ~m_mem_ready_i;
    assign load_use_s = is_load_use(E_opcode_i, E_rd_i, D_rs1_i, D_rs2_i);

    // Stage controls: reset squash, then memory wait, mispredict, load-use.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        E_stall_o  = 1'b0;
        M_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_bubble_o = 1'b0;
        if (rst_i) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
            W_bubble_o = 1'b1;
        end else if (mem_wait_s) begin
            // Freeze everything up to memory; writeback gets a bubble.
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_stall_o  = 1'b1;
            W_bubble_o = 1'b1;
        end else if (e_mispredict_i) begin
            // Wrong-path instructions in decode and execute are squashed;
            // this also removes any load-use victim sitting in decode.
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
        end else if (load_use_s) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_bubble_o = 1'b1;
        end else begin
            F_stall_o  = 1'b0;
        end
    end

    // Next state and wait counter. The entry cycle counts as the first wait
    // cycle, so a limit of N flags after the Nth consecutive wait cycle.
    always_comb begin
        state_next_s  = ST_RUN;
        wait_next_s   = '0;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_RUN:      wait_inc_s = WAIT_W'(1);
            ST_MEM_WAIT: wait_inc_s = wait_cnt_r + WAIT_W'(1);
            default:     wait_inc_s = WAIT_W'(1);
        endcase
        if (mem_wait_s) begin
            if (wait_inc_s >= TIMEOUT_CMP) begin
                // Give up on this wait: flag it and drop back to RUN.
                timeout_set_s = 1'b1;
                state_next_s  = ST_RUN;
                wait_next_s   = '0;
            end else begin
                state_next_s  = ST_MEM_WAIT;
                wait_next_s   = wait_inc_s;
            end
        end else begin
            state_next_s = ST_RUN;
            wait_next_s  = '0;
        end
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_next_s;
            timeout_r  <= timeout_r | timeout_set_s;
        end
    end

    assign mem_timeout_o = timeout_r;

`ifdef PIPE_CTRL_PERF_EN
    logic flush_evt_s;

    // Only mispredicts actually acted on are counted; one held off by a
    // memory wait is counted when it is finally applied.
    assign flush_evt_s = e_mispredict_i & ~mem_wait_s & ~rst_i;

    pipe_ctrl_perf_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (F_stall_o),
        .count (stall_cnt_o)
    );

    pipe_ctrl_perf_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (flush_evt_s),
        .count (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, table-driven bench for pipe_ctrl (MEM_TIMEOUT=4).
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 32;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [7:0] O_IDLE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_0100;
    localparam logic [7:0] O_MISP = 8'b0000_1100;
    localparam logic [7:0] O_MEMW = 8'b1111_0001;
    localparam logic [7:0] O_RST  = 8'b0000_1111;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1, rs2, rd;
    logic [6:0]       opcode;
    logic             misp, req, ready;
    logic             f_st, d_st, e_st, m_st, d_bb, e_bb, m_bb, w_bb;
    logic             tmo;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;
    int stall_m = 0;
    int flush_m = 0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] opcode;
        logic [4:0] rd;
        logic       misp;
        logic       req;
        logic       ready;
        logic [7:0] exp;   // {F,D,E,M stall, D,E,M,W bubble}
    } vec_t;

    vec_t vecs [12];

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .D_rs1_i        (rs1),
        .D_rs2_i        (rs2),
        .E_opcode_i     (opcode),
        .E_rd_i         (rd),
        .e_mispredict_i (misp),
        .m_mem_req_i    (req),
        .m_mem_ready_i  (ready),
        .F_stall_o      (f_st),
        .D_stall_o      (d_st),
        .E_stall_o      (e_st),
        .M_stall_o      (m_st),
        .D_bubble_o     (d_bb),
        .E_bubble_o     (e_bb),
        .M_bubble_o     (m_bb),
        .W_bubble_o     (w_bb),
        .mem_timeout_o  (tmo),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {f_st, d_st, e_st, m_st, d_bb, e_bb, m_bb, w_bb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counter check: with the counters built they track the model, else zero.
    task automatic check_cnt(input string name);
`ifdef PIPE_CTRL_PERF_EN
        check({name, "_stall_cnt"}, stall_cnt, 32'(stall_m));
        check({name, "_flush_cnt"}, flush_cnt, 32'(flush_m));
`else
        check({name, "_stall_cnt"}, stall_cnt, 32'd0);
        check({name, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; opcode = OP_ALU;
        misp = 1'b0; req = 1'b0; ready = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        @(negedge clk);
        check({name, "_outs_in_reset"}, 32'(outs()), 32'(O_RST));
        tick();
        rst = 1'b0;
        stall_m = 0;
        flush_m = 0;
        @(negedge clk);
        check({name, "_timeout"}, 32'(tmo), 32'd0);
        check({name, "_state"}, 32'(dut.state_r), 32'(ST_RUN));
        check_cnt(name);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_in();

        //            rs1    rs2    opcode   rd     misp  req   ready exp
        vecs[0]  = '{5'd0, 5'd0, OP_ALU,  5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[1]  = '{5'd3, 5'd5, OP_LOAD, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd7, 5'd2, OP_LOAD, 5'd7, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[3]  = '{5'd0, 5'd4, OP_LOAD, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[4]  = '{5'd5, 5'd5, OP_ALU,  5'd5, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[5]  = '{5'd6, 5'd7, OP_LOAD, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[6]  = '{5'd1, 5'd2, OP_ALU,  5'd3, 1'b1, 1'b0, 1'b0, O_MISP};
        vecs[7]  = '{5'd9, 5'd1, OP_LOAD, 5'd9, 1'b1, 1'b0, 1'b0, O_MISP};
        vecs[8]  = '{5'd0, 5'd0, OP_ALU,  5'd0, 1'b0, 1'b1, 1'b0, O_MEMW};
        vecs[9]  = '{5'd9, 5'd1, OP_LOAD, 5'd9, 1'b1, 1'b1, 1'b0, O_MEMW};
        vecs[10] = '{5'd9, 5'd1, OP_LOAD, 5'd8, 1'b0, 1'b1, 1'b1, O_IDLE};
        vecs[11] = '{5'd0, 5'd0, OP_ALU,  5'd0, 1'b0, 1'b0, 1'b1, O_IDLE};

        // Reset state (outputs while in reset, registers afterwards).
        tick();
        do_reset("init");

        // Single-cycle vectors; the counter model advances per applied cycle.
        for (int i = 0; i < 12; i++) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; opcode = vecs[i].opcode;
            rd = vecs[i].rd; misp = vecs[i].misp; req = vecs[i].req; ready = vecs[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            check_cnt($sformatf("vec%0d", i));
            if (vecs[i].exp[7]) stall_m++;
            if (vecs[i].misp && !(vecs[i].req && !vecs[i].ready)) flush_m++;
            tick();
        end
        idle_in();
        @(negedge clk);
        check_cnt("table_end");
        check("table_timeout", 32'(tmo), 32'd0);
        tick();

        // Load-use lasts exactly the cycle it is presented.
        do_reset("lu");
        rs2 = 5'd5; rd = 5'd5; opcode = OP_LOAD;
        @(negedge clk);
        check("lu_cycle1", 32'(outs()), 32'(O_LU));
        tick();
        idle_in();
        @(negedge clk);
        check("lu_cycle2", 32'(outs()), 32'(O_IDLE));
        tick();

        // Three wait cycles then ready: stall 3 cycles, fourth clean.
        do_reset("memw");
        req = 1'b1; ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("memw_cycle%0d", k), 32'(outs()), 32'(O_MEMW));
            tick();
        end
        ready = 1'b1;
        @(negedge clk);
        check("memw_cycle4", 32'(outs()), 32'(O_IDLE));
        tick();
        idle_in();
        @(negedge clk);
        stall_m = 3;
        check_cnt("memw");
        check("memw_state", 32'(dut.state_r), 32'(ST_RUN));
        check("memw_timeout", 32'(tmo), 32'd0);
        tick();

        // Timeout after the 4th consecutive wait cycle; flag is sticky.
        do_reset("tmo");
        req = 1'b1; ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("tmo_outs%0d", k), 32'(outs()), 32'(O_MEMW));
            check($sformatf("tmo_flag_before%0d", k), 32'(tmo), 32'd0);
            tick();
            check($sformatf("tmo_state%0d", k), 32'(dut.state_r),
                  (k < 4) ? 32'(ST_MEM_WAIT) : 32'(ST_RUN));
        end
        @(negedge clk);
        check("tmo_flag_set", 32'(tmo), 32'd1);
        tick();
        idle_in();
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk);
        check("tmo_flag_sticky", 32'(tmo), 32'd1);
        check("tmo_idle_outs", 32'(outs()), 32'(O_IDLE));
        tick();
        do_reset("tmo_clear");

        // Reset mid-wait abandons the wait count.
        req = 1'b1; ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        @(negedge clk);
        check("rstw_outs", 32'(outs()), 32'(O_RST));
        tick();
        rst = 1'b0;
        req = 1'b0;
        stall_m = 0;
        flush_m = 0;
        @(negedge clk);
        check("rstw_state", 32'(dut.state_r), 32'(ST_RUN));
        check("rstw_wait_cnt", 32'(dut.wait_cnt_r), 32'd0);
        check("rstw_timeout", 32'(tmo), 32'd0);
        check_cnt("rstw");
        tick();
        req = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        @(negedge clk);
        check("rstw_no_timeout", 32'(tmo), 32'd0);
        tick();
        idle_in();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
